// File: rtl/axi_stride_reader_pkg.sv
// Shared types and constants for the strided AXI read engine:
// FSM state encoding and the bit positions of the sticky error flags.
package axi_stride_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_GAP
  } state_e;

  localparam int ERR_FLAGS_W      = 4;
  localparam int ERR_ID           = 0;
  localparam int ERR_EARLY_LAST   = 1;
  localparam int ERR_MISSING_LAST = 2;
  localparam int ERR_DATA         = 3;

endpackage

// File: rtl/axi_stride_reader_if.sv
// AXI read-address and read-data channel subset used by the stride reader.
// The master modport is the reader side; the slave modport is the memory side.
interface axi_stride_reader_if #(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8
);

  logic                       m_ar_valid;
  logic                       m_ar_ready;
  logic [ADDR_BITS-1:0]       m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len;
  logic [TID_WIDTH-1:0]       m_ar_id;

  logic                       m_r_valid;
  logic                       m_r_ready;
  logic [DATA_WIDTH-1:0]      m_r_data;
  logic                       m_r_last;
  logic [TID_WIDTH-1:0]       m_r_id;

  modport master (
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
  );

  modport slave (
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
  );

endinterface

// File: rtl/stride_reader_beat_chk.sv
// Per-beat response checker: id/last protocol checks, error counting and XOR checksum.
// Define AXI_STRIDE_READER_DATA_CHECK_EN to also compare each beat against seed+n.
module stride_reader_beat_chk
  import axi_stride_reader_pkg::*;
#(
  parameter int TID_WIDTH     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int REQ_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     clear_i,
  input  logic                     beat_i,
  input  logic                     last_exp_i,
  input  logic [TID_WIDTH-1:0]     exp_id_i,
  input  logic [DATA_WIDTH-1:0]    seed_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic [TID_WIDTH-1:0]     id_i,
  input  logic                     last_i,
  output logic [REQ_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ERR_FLAGS_W-1:0]   err_flags_o,
  output logic [DATA_WIDTH-1:0]    checksum_o
);

  logic [REQ_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_FLAGS_W-1:0]   err_flags_q, err_flags_d;
  logic [DATA_WIDTH-1:0]    checksum_q, checksum_d;
  logic                     id_err, early_err, missing_err, data_err;

  assign id_err      = (id_i != exp_id_i);
  assign early_err   = last_i && !last_exp_i;
  assign missing_err = !last_i && last_exp_i;

`ifdef AXI_STRIDE_READER_DATA_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;

  assign data_err = (data_i != exp_data_q);

  always_comb begin
    exp_data_d = exp_data_q;
    if (clear_i)     exp_data_d = seed_i;
    else if (beat_i) exp_data_d = exp_data_q + DATA_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) exp_data_q <= '0;
    else         exp_data_q <= exp_data_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^seed_i;
  assign data_err    = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    err_cnt_d   = err_cnt_q;
    err_flags_d = err_flags_q;
    checksum_d  = checksum_q;
    if (clear_i) begin
      err_cnt_d   = '0;
      err_flags_d = '0;
      checksum_d  = '0;
    end else if (beat_i) begin
      err_flags_d[ERR_ID]           = err_flags_q[ERR_ID]           | id_err;
      err_flags_d[ERR_EARLY_LAST]   = err_flags_q[ERR_EARLY_LAST]   | early_err;
      err_flags_d[ERR_MISSING_LAST] = err_flags_q[ERR_MISSING_LAST] | missing_err;
      err_flags_d[ERR_DATA]         = err_flags_q[ERR_DATA]         | data_err;
      // One count per bad beat, however many checks it failed; saturates.
      if ((id_err || early_err || missing_err || data_err) && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + REQ_CNT_WIDTH'(1);
      checksum_d = checksum_q ^ data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      checksum_q  <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      err_flags_q <= err_flags_d;
      checksum_q  <= checksum_d;
    end
  end

  assign err_cnt_o   = err_cnt_q;
  assign err_flags_o = err_flags_q;
  assign checksum_o  = checksum_q;

endmodule

// File: rtl/axi_stride_reader.sv
// Issues cfg_reqNum single-outstanding AXI read bursts at base + k*stride and checks the responses.
// Optional AXI_STRIDE_READER_DATA_CHECK_EN adds an incrementing-data compare in the beat checker.
module axi_stride_reader
  import axi_stride_reader_pkg::*;
#(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int REQ_CNT_WIDTH   = 8,
  parameter int GAP_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       en,
  input  logic                       start,
  input  logic [ADDR_BITS-1:0]       cfg_base,
  input  logic [ADDR_BITS-1:0]       cfg_stride,
  input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
  input  logic [TID_WIDTH-1:0]       cfg_id,
  input  logic [REQ_CNT_WIDTH-1:0]   cfg_reqNum,
  input  logic [GAP_WIDTH-1:0]       cfg_gap,
  input  logic [DATA_WIDTH-1:0]      cfg_seed,
  axi_stride_reader_if.master        m_axi,
  output logic                       busy,
  output logic                       done,
  output logic [REQ_CNT_WIDTH-1:0]   errCnt,
  output logic [ERR_FLAGS_W-1:0]     errFlags,
  output logic [DATA_WIDTH-1:0]      checksum
);

  state_e                     state_q, state_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [ADDR_BITS-1:0]       stride_q, stride_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [BURST_LEN_WIDTH-1:0] beat_q, beat_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [REQ_CNT_WIDTH-1:0]   req_left_q, req_left_d;
  logic [GAP_WIDTH-1:0]       gap_q, gap_d;
  logic [GAP_WIDTH-1:0]       gap_cnt_q, gap_cnt_d;
  logic                       done_q, done_d;

  logic r_ready, r_fire, last_exp, burst_end, run_start;

  // ar_valid stays up through an en freeze so it never drops before its handshake.
  assign r_ready   = (state_q == S_DATA) && en;
  assign r_fire    = r_ready && m_axi.m_r_valid;
  assign last_exp  = (beat_q == len_q);
  assign burst_end = r_fire && (last_exp || m_axi.m_r_last);
  assign run_start = en && (state_q == S_IDLE) && start && (cfg_reqNum != '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    beat_d     = beat_q;
    id_d       = id_q;
    req_left_d = req_left_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = done_q;
    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_reqNum != '0) begin
              addr_d     = cfg_base;
              stride_d   = cfg_stride;
              len_d      = cfg_len;
              id_d       = cfg_id;
              req_left_d = cfg_reqNum;
              gap_d      = cfg_gap;
              state_d    = S_ADDR;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (m_axi.m_ar_ready) begin
            beat_d  = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (r_fire) beat_d = beat_q + BURST_LEN_WIDTH'(1);
          if (burst_end) begin
            req_left_d = req_left_q - REQ_CNT_WIDTH'(1);
            if (req_left_q == REQ_CNT_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              addr_d    = addr_q + stride_q;
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end
        end
        S_GAP: begin
          // Gap of 0 or 1 both spend exactly one cycle here.
          if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = S_ADDR;
          else                            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      id_q       <= '0;
      req_left_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      id_q       <= id_d;
      req_left_q <= req_left_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
    end
  end

  assign m_axi.m_ar_valid = (state_q == S_ADDR);
  assign m_axi.m_ar_addr  = addr_q;
  assign m_axi.m_ar_len   = len_q;
  assign m_axi.m_ar_id    = id_q;
  assign m_axi.m_r_ready  = r_ready;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;

  stride_reader_beat_chk #(
    .TID_WIDTH    (TID_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .REQ_CNT_WIDTH(REQ_CNT_WIDTH)
  ) u_beat_chk (
    .clk        (clk),
    .resetN     (resetN),
    .clear_i    (run_start),
    .beat_i     (r_fire),
    .last_exp_i (last_exp),
    .exp_id_i   (id_q),
    .seed_i     (cfg_seed),
    .data_i     (m_axi.m_r_data),
    .id_i       (m_axi.m_r_id),
    .last_i     (m_axi.m_r_last),
    .err_cnt_o  (errCnt),
    .err_flags_o(errFlags),
    .checksum_o (checksum)
  );

endmodule

// File: tb/tb_axi_stride_reader.sv
// Directed bench for axi_stride_reader: address walk, wrap, gap timing, id/last/data errors,
// zero-request run, en freeze and mid-burst reset, with hand-computed expectations.
module tb_axi_stride_reader;

  logic        clk = 1'b0;
  logic        resetN, en, start;
  logic [15:0] cfg_base, cfg_stride;
  logic [7:0]  cfg_len, cfg_id, cfg_reqNum, cfg_gap, cfg_seed;
  logic        busy, done;
  logic [7:0]  errCnt;
  logic [3:0]  errFlags;
  logic [7:0]  checksum;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  axi_stride_reader_if bus ();

  axi_stride_reader dut (
    .clk       (clk),
    .resetN    (resetN),
    .en        (en),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_stride(cfg_stride),
    .cfg_len   (cfg_len),
    .cfg_id    (cfg_id),
    .cfg_reqNum(cfg_reqNum),
    .cfg_gap   (cfg_gap),
    .cfg_seed  (cfg_seed),
    .m_axi     (bus.master),
    .busy      (busy),
    .done      (done),
    .errCnt    (errCnt),
    .errFlags  (errFlags),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] base, input logic [15:0] stride, input logic [7:0] len,
                          input logic [7:0] id, input logic [7:0] reqn, input logic [7:0] gap,
                          input logic [7:0] seed);
    @(negedge clk);
    cfg_base = base; cfg_stride = stride; cfg_len = len; cfg_id = id;
    cfg_reqNum = reqn; cfg_gap = gap; cfg_seed = seed;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the inputs so only latched values can produce the expected results.
    cfg_base = ~base; cfg_stride = ~stride; cfg_len = ~len; cfg_id = ~id;
    cfg_gap = ~gap; cfg_seed = ~seed;
  endtask

  task automatic wait_ar(input string tag, input logic [15:0] exp_addr, input logic [7:0] exp_len,
                         input logic [7:0] exp_id, input int exp_wait);
    int waited = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.m_ar_valid) begin
        seen = 1'b1;
        break;
      end
      waited++;
    end
    check({tag, " ar_valid seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " ar_addr"}, 32'(bus.m_ar_addr), 32'(exp_addr));
      check({tag, " ar_len"},  32'(bus.m_ar_len),  32'(exp_len));
      check({tag, " ar_id"},   32'(bus.m_ar_id),   32'(exp_id));
      if (exp_wait >= 0) check({tag, " idle cycles before ar"}, 32'(waited), 32'(exp_wait));
      bus.m_ar_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.m_ar_ready = 1'b0;
    end
  endtask

  task automatic send_beat(input string tag, input logic [7:0] data, input logic [7:0] id,
                           input logic last);
    bit rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.m_r_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    check({tag, " r_ready seen"}, 32'(rdy), 32'd1);
    bus.m_r_valid = 1'b1;
    bus.m_r_data  = data;
    bus.m_r_id    = id;
    bus.m_r_last  = last;
    @(posedge clk);
    #1;
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic [3:0] exp_flags, input logic [7:0] exp_cnt,
                           input logic [7:0] exp_cs, input int exp_done_cnt);
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd1);
    check({tag, " busy after run"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done falls"}, 32'(done), 32'd0);
    check({tag, " errFlags"}, 32'(errFlags), 32'(exp_flags));
    check({tag, " errCnt"}, 32'(errCnt), 32'(exp_cnt));
    check({tag, " checksum"}, 32'(checksum), 32'(exp_cs));
    check({tag, " done count"}, 32'(done_cnt), 32'(exp_done_cnt));
  endtask

  initial begin
    int dc;
    resetN = 1'b0; en = 1'b1; start = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_len = '0; cfg_id = '0;
    cfg_reqNum = '0; cfg_gap = '0; cfg_seed = '0;
    bus.m_ar_ready = 1'b0; bus.m_r_valid = 1'b0; bus.m_r_data = '0;
    bus.m_r_last = 1'b0; bus.m_r_id = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ar_valid", 32'(bus.m_ar_valid), 32'd0);
    check("reset r_ready", 32'(bus.m_r_ready), 32'd0);
    check("reset errCnt", 32'(errCnt), 32'd0);
    check("reset errFlags", 32'(errFlags), 32'd0);
    check("reset checksum", 32'(checksum), 32'd0);
    resetN = 1'b1;

    // Four single-beat requests, stride 1, gap 6: data 0x31..0x34 XOR to 0x04.
    do_start(16'h0eef, 16'h0001, 8'd0, 8'h21, 8'd4, 8'd6, 8'h31);
    wait_ar("t1 req0", 16'h0eef, 8'd0, 8'h21, 0);
    send_beat("t1 b0", 8'h31, 8'h21, 1'b1);
    wait_ar("t1 req1", 16'h0ef0, 8'd0, 8'h21, 6);
    send_beat("t1 b1", 8'h32, 8'h21, 1'b1);
    wait_ar("t1 req2", 16'h0ef1, 8'd0, 8'h21, 6);
    send_beat("t1 b2", 8'h33, 8'h21, 1'b1);
    wait_ar("t1 req3", 16'h0ef2, 8'd0, 8'h21, 6);
    send_beat("t1 b3", 8'h34, 8'h21, 1'b1);
    check_end("t1", 4'b0000, 8'd0, 8'h04, 1);

    // Address wrap at 2^16; ar_ready withheld to confirm valid/addr hold.
    do_start(16'hfffe, 16'h0003, 8'd0, 8'h02, 8'd3, 8'd0, 8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2 ar_valid held", 32'(bus.m_ar_valid), 32'd1);
      check("t2 ar_addr held", 32'(bus.m_ar_addr), 32'h0000fffe);
    end
    wait_ar("t2 req0", 16'hfffe, 8'd0, 8'h02, 0);
    send_beat("t2 b0", 8'h40, 8'h02, 1'b1);
    wait_ar("t2 req1", 16'h0001, 8'd0, 8'h02, 1);
    send_beat("t2 b1", 8'h41, 8'h02, 1'b1);
    wait_ar("t2 req2", 16'h0004, 8'd0, 8'h02, 1);
    send_beat("t2 b2", 8'h42, 8'h02, 1'b1);
    check_end("t2", 4'b0000, 8'd0, 8'h43, 2);

    // Early last on beat 1 of a 3-beat burst; en dropped for 4 cycles inside the gap.
    do_start(16'h1000, 16'h0100, 8'd2, 8'h03, 8'd2, 8'd2, 8'h50);
    wait_ar("t3 req0", 16'h1000, 8'd2, 8'h03, 0);
    send_beat("t3 b0", 8'h50, 8'h03, 1'b0);
    send_beat("t3 b1", 8'h51, 8'h03, 1'b1);
    en = 1'b0;
    @(negedge clk);
    check("t3 frozen busy", 32'(busy), 32'd1);
    check("t3 frozen flags", 32'(errFlags), 32'b0010);
    repeat (4) @(posedge clk);
    #1;
    en = 1'b1;
    wait_ar("t3 req1", 16'h1100, 8'd2, 8'h03, 2);
    send_beat("t3 b2", 8'h52, 8'h03, 1'b0);
    send_beat("t3 b3", 8'h53, 8'h03, 1'b0);
    send_beat("t3 b4", 8'h54, 8'h03, 1'b1);
    check_end("t3", 4'b0010, 8'd1, 8'h54, 3);

    // Wrong id on 2 of 4 beats; a start pulse mid-burst must not clear the count.
    do_start(16'h2000, 16'h0010, 8'd3, 8'h05, 8'd1, 8'd0, 8'h60);
    wait_ar("t4 req0", 16'h2000, 8'd3, 8'h05, 0);
    send_beat("t4 b0", 8'h60, 8'h05, 1'b0);
    send_beat("t4 b1", 8'h61, 8'h06, 1'b0);
    cfg_reqNum = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_beat("t4 b2", 8'h62, 8'h05, 1'b0);
    send_beat("t4 b3", 8'h63, 8'h06, 1'b1);
    check_end("t4", 4'b0001, 8'd2, 8'h00, 4);

    // Data 0x10,0x11,0x13 against seed 0x10: third beat is off by one.
    do_start(16'h3000, 16'h0000, 8'd2, 8'h07, 8'd1, 8'd0, 8'h10);
    wait_ar("t5 req0", 16'h3000, 8'd2, 8'h07, 0);
    send_beat("t5 b0", 8'h10, 8'h07, 1'b0);
    send_beat("t5 b1", 8'h11, 8'h07, 1'b0);
    send_beat("t5 b2", 8'h13, 8'h07, 1'b1);
`ifdef AXI_STRIDE_READER_DATA_CHECK_EN
    check_end("t5", 4'b1000, 8'd1, 8'h12, 5);
`else
    check_end("t5", 4'b0000, 8'd0, 8'h12, 5);
`endif

    // Zero-request start: done pulse next cycle, never busy.
    do_start(16'h4000, 16'h0001, 8'd0, 8'h01, 8'd0, 8'd0, 8'h00);
    @(negedge clk);
    check("t6 done pulse", 32'(done), 32'd1);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 no ar", 32'(bus.m_ar_valid), 32'd0);
    @(negedge clk);
    check("t6 done falls", 32'(done), 32'd0);
    check("t6 done count", 32'(done_cnt), 32'd6);

    // Reset asserted in DATA while r_valid is high.
    do_start(16'h5000, 16'h0001, 8'd3, 8'h09, 8'd1, 8'd0, 8'h77);
    wait_ar("t7 req0", 16'h5000, 8'd3, 8'h09, 0);
    send_beat("t7 b0", 8'h77, 8'h09, 1'b0);
    check("t7 checksum before reset", 32'(checksum), 32'h77);
    @(negedge clk);
    check("t7 r_ready before reset", 32'(bus.m_r_ready), 32'd1);
    bus.m_r_valid = 1'b1;
    bus.m_r_data  = 8'h78;
    bus.m_r_id    = 8'h09;
    dc = done_cnt;
    #1;
    resetN = 1'b0;
    #1;
    check("t7 r_ready in reset", 32'(bus.m_r_ready), 32'd0);
    check("t7 busy in reset", 32'(busy), 32'd0);
    check("t7 checksum in reset", 32'(checksum), 32'd0);
    check("t7 errCnt in reset", 32'(errCnt), 32'd0);
    repeat (2) @(negedge clk);
    bus.m_r_valid = 1'b0;
    resetN = 1'b1;
    repeat (4) @(negedge clk);
    check("t7 idle after reset", 32'(busy), 32'd0);
    check("t7 no ar after reset", 32'(bus.m_ar_valid), 32'd0);
    check("t7 no done after reset", 32'(done_cnt), 32'(dc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stride_reader.md
AXI_STRIDE_READER -- requirements
Module: axi_stride_reader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, AR address width.
REQ-002 SHALL have parameter BURST_LEN_WIDTH, default 8, AR len width.
REQ-003 SHALL have parameter TID_WIDTH, default 8, AR/R ID width.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, R data width.
REQ-005 SHALL have parameter REQ_CNT_WIDTH, default 8, request-count and error-count width.
REQ-006 SHALL have parameter GAP_WIDTH, default 8, inter-request gap width.
REQ-007 clk  in  1  sole clock, rising edge; resetN  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  gates all state advance; start  in  1  pulse, sampled only in IDLE.
REQ-009 cfg_base  in  ADDR_BITS  first address; cfg_stride  in  ADDR_BITS  address increment.
REQ-010 cfg_len  in  BURST_LEN_WIDTH  AXI len (beats-1); cfg_id  in  TID_WIDTH  request ID.
REQ-011 cfg_reqNum  in  REQ_CNT_WIDTH  request count; cfg_gap  in  GAP_WIDTH  idle cycles between requests; cfg_seed  in  DATA_WIDTH  first expected data word.
REQ-012 m_ar_valid  out  1; m_ar_ready  in  1; m_ar_addr  out  ADDR_BITS; m_ar_len  out  BURST_LEN_WIDTH; m_ar_id  out  TID_WIDTH.
REQ-013 m_r_valid  in  1; m_r_ready  out  1; m_r_data  in  DATA_WIDTH; m_r_last  in  1; m_r_id  in  TID_WIDTH.
REQ-014 busy  out  1; done  out  1 (one-cycle pulse); errCnt  out  REQ_CNT_WIDTH; errFlags  out  4 (sticky); checksum  out  DATA_WIDTH.

Function
REQ-015 SHALL implement FSM IDLE -> ADDR -> DATA -> GAP -> ADDR ..., DATA/GAP -> IDLE after the last request; en=0 freezes state, counters, and holds outputs.
REQ-016 IDLE & start & cfg_reqNum!=0: latch all cfg_* inputs, clear errCnt/errFlags/checksum, go to ADDR next cycle; cfg_reqNum=0: done pulses next cycle, state stays IDLE.
REQ-017 ADDR: m_ar_valid=1 with addr/len/id stable until m_ar_ready; on handshake go to DATA; valid SHALL NOT drop before handshake.
REQ-018 Request k address = latched base + k*stride, modulo 2^ADDR_BITS (wraps silently).
REQ-019 DATA: m_r_ready=1; exactly one outstanding burst; each beat handshake increments beat index; after beat cfg_len (last expected) -> GAP, or IDLE with done pulse if it was the final request.
REQ-020 GAP: count cfg_gap cycles then ADDR; cfg_gap=0 goes ADDR the next cycle.
REQ-021 Per beat: m_r_id != latched id sets errFlags[0]; m_r_last=1 before final beat sets errFlags[1] and ends the burst early; m_r_last=0 on final beat sets errFlags[2]; errCnt increments once per erroneous beat, saturating at all-ones.
REQ-022 checksum = XOR of all received beat data of the run.
REQ-023 busy=1 in every state except IDLE.
REQ-024 start outside IDLE SHALL be ignored.

Reset
REQ-025 resetN low SHALL asynchronously force IDLE and m_ar_valid=0, m_r_ready=0, busy=0, done=0, errCnt=0, errFlags=0, checksum=0, all addresses/counters 0; mid-burst reset abandons the run with no done pulse.

Configuration
REQ-026 Macro AXI_STRIDE_READER_DATA_CHECK_EN defined: beat n of the run (counted from 0 across all requests) SHALL equal cfg_seed+n mod 2^DATA_WIDTH, mismatch sets errFlags[3] and counts in errCnt; undefined: no compare, errFlags[3] tied 0.

Structure
REQ-027 Package axi_stride_reader_pkg SHALL hold the FSM state enum and the errFlags bit-index constants (ERR_ID=0, ERR_EARLY_LAST=1, ERR_MISSING_LAST=2, ERR_DATA=3).
REQ-028 Beat checking (id, last, data compare, checksum) SHALL live in one sub-module stride_reader_beat_chk; address/FSM logic stays in the top.

Verification
REQ-029 base=0x0eef, stride=1, len=0, reqNum=4, gap=6, responder always ready -> AR addresses 0x0eef,0x0ef0,0x0ef1,0x0ef2, each 1 beat, done once, errFlags=0.
REQ-030 base=0xfffe, stride=3, reqNum=3 -> addresses 0xfffe, 0x0001, 0x0004 (wrap).
REQ-031 len=2, responder asserts last on beat 1 -> errFlags[1]=1, errCnt=1, next AR issued after gap.
REQ-032 responder returns id 6 while cfg_id=5 on 2 of 4 beats -> errFlags[0]=1, errCnt=2.
REQ-033 with DATA_CHECK_EN, seed=0x10, data 0x10,0x11,0x13 -> errFlags[3]=1, errCnt=1; without macro -> errFlags=0, checksum=0x12.
REQ-034 resetN dropped in DATA with m_r_valid high -> m_r_ready=0 and busy=0 immediately; no done pulse.
